// File: rtl/mips_defs.sv
// Shared MIPS memory-stage definitions: opcodes, exception codes, FSM state
// encoding and small decode helpers used by the memory controller.
package mips_defs;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_ADEL    = 2'b01;
  localparam logic [1:0] EXC_ADES    = 2'b10;
  localparam logic [1:0] EXC_TIMEOUT = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  // Word ops need a 4-byte aligned address, half ops a 2-byte aligned one.
  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] ar_lo);
    logic mis;
    mis = 1'b0;
    case (op)
      OP_LW, OP_SW:         mis = (ar_lo != 2'b00);
      OP_LH, OP_LHU, OP_SH: mis = ar_lo[0];
      default:              mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] byte_en(input logic [5:0] op, input logic [1:0] ar_lo);
    logic [3:0] be;
    be = 4'b1111;
    case (op)
      OP_SH:   be = ar_lo[1] ? 4'b1100 : 4'b0011;
      OP_SB:   be = 4'b0001 << ar_lo;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate narrow store data across lanes so the byte enables pick the lane.
  function automatic logic [31:0] write_data(input logic [5:0] op, input logic [31:0] v2);
    logic [31:0] wd;
    wd = v2;
    case (op)
      OP_SH:   wd = {2{v2[15:0]}};
      OP_SB:   wd = {4{v2[7:0]}};
      default: wd = v2;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/m_load_ext.sv
// Selects the addressed half/byte of a loaded word and sign/zero extends it.
module m_load_ext
  import mips_defs::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  ar_lo,
  input  logic [31:0] word,
  output logic [31:0] ldata
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  // Lane selection by address bits, then extension by load type.
  always_comb begin
    half_sel = ar_lo[1] ? word[31:16] : word[15:0];
    case (ar_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    case (op)
      OP_LW:   ldata = word;
      OP_LH:   ldata = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  ldata = {16'h0, half_sel};
      OP_LB:   ldata = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  ldata = {24'h0, byte_sel};
      default: ldata = 32'h0;
    endcase
  end

endmodule

// File: rtl/m_mem_ctrl.sv
// M-stage memory controller: issues one bus access per load/store, stalls the
// pipeline until the access finishes, and reports alignment/timeout exceptions.
// Bus handshake: mem_req and its address/data/enables are held constant from
// the first BUSY cycle until the cycle mem_ready=1; mem_ready outside BUSY has
// no effect.
module m_mem_ctrl
  import mips_defs::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_instr,
  input  logic [31:0] M_AR,
  input  logic [31:0] M_V2,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        m_stall,
  output logic [31:0] m_ldata,
  output logic [1:0]  m_exc,
  output logic [1:0]  dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state;
  logic [5:0]       op;
  logic             op_is_load;
  logic             op_is_mem;
  logic [5:0]       op_q;
  logic [1:0]       ar_lo_q;
  logic [31:0]      rdata_q;
  logic [1:0]       exc_q;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      ext_data;
  logic             unused_instr_bits;

  assign op                = M_instr[31:26];
  assign op_is_load        = is_load(op);
  assign op_is_mem         = op_is_load || is_store(op);
  assign unused_instr_bits = ^M_instr[25:0];
  assign dbg_state         = state;

  // Access sequencing: IDLE issues or faults, BUSY waits for ready/timeout,
  // DONE presents the result for exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'h0;
      op_q      <= 6'h0;
      ar_lo_q   <= 2'b00;
      rdata_q   <= 32'h0;
      exc_q     <= EXC_NONE;
      wait_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (op_is_mem) begin
            op_q     <= op;
            ar_lo_q  <= M_AR[1:0];
            rdata_q  <= 32'h0;
            wait_cnt <= '0;
            if (is_misaligned(op, M_AR[1:0])) begin
              exc_q <= op_is_load ? EXC_ADEL : EXC_ADES;
              state <= ST_DONE;
            end else begin
              exc_q     <= EXC_NONE;
              mem_req   <= 1'b1;
              mem_we    <= ~op_is_load;
              mem_addr  <= {M_AR[31:2], 2'b00};
              mem_be    <= byte_en(op, M_AR[1:0]);
              mem_wdata <= write_data(op, M_V2);
              state     <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          // A ready in the final counted cycle still completes normally.
          if (mem_ready) begin
            rdata_q <= mem_rdata;
            mem_req <= 1'b0;
            state   <= ST_DONE;
          end else if (wait_cnt == TO_LAST) begin
            mem_req <= 1'b0;
            exc_q   <= EXC_TIMEOUT;
            state   <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  m_load_ext u_load_ext (
    .op    (op_q),
    .ar_lo (ar_lo_q),
    .word  (rdata_q),
    .ldata (ext_data)
  );

  // Results are only visible during DONE; faulted or store accesses return 0.
  always_comb begin
    m_stall = op_is_mem && (state != ST_DONE);
    m_exc   = (state == ST_DONE) ? exc_q : EXC_NONE;
    m_ldata = ((state == ST_DONE) && is_load(op_q) && (exc_q == EXC_NONE)) ? ext_data : 32'h0;
  end

endmodule

// File: tb/tb_m_mem_ctrl.sv
// Directed bench for m_mem_ctrl: a vector table of memory ops run back to back,
// plus hand-written sequences for reset, idle ready pulses and reset in BUSY.
module tb_m_mem_ctrl;
  import mips_defs::*;

  logic        clk;
  logic        reset;
  logic [31:0] M_instr, M_AR, M_V2;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        m_stall;
  logic [31:0] m_ldata;
  logic [1:0]  m_exc;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [33:0] exp_q[$];

  typedef struct {
    logic [5:0]  op;
    logic [31:0] ar;
    logic [31:0] v2;
    logic [31:0] rdata;
    int          ready_wait;   // BUSY cycle index carrying mem_ready, -1 = never
    int          exp_busy;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_ldata;
    logic [1:0]  exp_exc;
    int          exp_stalls;
  } vec_t;

  vec_t vecs[17];

  m_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .M_instr   (M_instr),
    .M_AR      (M_AR),
    .M_V2      (M_V2),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .m_stall   (m_stall),
    .m_ldata   (m_ldata),
    .m_exc     (m_exc),
    .dbg_state (dbg_state)
  );

  // Clock and global watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [5:0] op, input logic [31:0] ar, input logic [31:0] v2,
                              input logic [31:0] rdata, input int rw, input int busy,
                              input logic we, input logic [3:0] be, input logic [31:0] wd,
                              input logic [31:0] ld, input logic [1:0] exc, input int st);
    vec_t v;
    v.op = op; v.ar = ar; v.v2 = v2; v.rdata = rdata; v.ready_wait = rw;
    v.exp_busy = busy; v.exp_we = we; v.exp_be = be; v.exp_wdata = wd;
    v.exp_ldata = ld; v.exp_exc = exc; v.exp_stalls = st;
    return v;
  endfunction

  // Driver: present one op, answer the bus, then score the DONE cycle.
  task automatic run_op(input int idx, input vec_t v);
    int          stalls;
    int          busy;
    bit          done;
    logic        we_c;
    logic [3:0]  be_c;
    logic [31:0] addr_c, wd_c;
    logic [33:0] exp;
    stalls = 0; busy = 0; done = 0;
    we_c = 1'b0; be_c = 4'h0; addr_c = 32'h0; wd_c = 32'h0;
    @(negedge clk);
    M_instr = {v.op, 26'h0}; M_AR = v.ar; M_V2 = v.v2;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    exp_q.push_back({v.exp_exc, v.exp_ldata});
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (!m_stall) begin
        done = 1;
        exp = exp_q.pop_front();
        chk($sformatf("v%0d ldata", idx), m_ldata, exp[31:0]);
        chk($sformatf("v%0d exc", idx), {30'h0, m_exc}, {30'h0, exp[33:32]});
        chk($sformatf("v%0d req_in_done", idx), {31'h0, mem_req}, 32'h0);
        mem_ready = 1'b1;            // stray ready in DONE must be ignored
        mem_rdata = 32'hFFFF_FFFF;
      end else begin
        stalls++;
        if (mem_req) begin
          if (busy == 0) begin
            we_c = mem_we; be_c = mem_be; addr_c = mem_addr; wd_c = mem_wdata;
          end else begin
            chk($sformatf("v%0d hold_addr", idx), mem_addr, addr_c);
            chk($sformatf("v%0d hold_ctl", idx), {27'h0, mem_we, mem_be}, {27'h0, we_c, be_c});
            chk($sformatf("v%0d hold_wdata", idx), mem_wdata, wd_c);
          end
          busy++;
          if (v.ready_wait == busy - 1) begin
            mem_ready = 1'b1; mem_rdata = v.rdata;
          end else begin
            mem_ready = 1'b0; mem_rdata = $urandom;
          end
        end
        @(negedge clk);
      end
    end
    if (!done) begin
      chk($sformatf("v%0d done_in_budget", idx), 32'h0, 32'h1);
      void'(exp_q.pop_front());
    end
    chk($sformatf("v%0d stalls", idx), stalls, v.exp_stalls);
    chk($sformatf("v%0d busy_cycles", idx), busy, v.exp_busy);
    if (busy > 0) begin
      chk($sformatf("v%0d we", idx), {31'h0, we_c}, {31'h0, v.exp_we});
      chk($sformatf("v%0d be", idx), {28'h0, be_c}, {28'h0, v.exp_be});
      chk($sformatf("v%0d addr", idx), addr_c, {v.ar[31:2], 2'b00});
      if (v.exp_we) chk($sformatf("v%0d wdata", idx), wd_c, v.exp_wdata);
    end
  endtask

  initial begin
    //            op      ar            v2            rdata         rw bsy we be     wdata         ldata         exc st
    vecs[0]  = mk(OP_LW,  32'h0000_0004, 32'h0,        32'h1234_5678, 0, 1, 0, 4'hF, 32'h0,        32'h1234_5678, 2'd0, 2);
    vecs[1]  = mk(OP_SB,  32'h0000_0003, 32'h0000_00AB, 32'h0,       0, 1, 1, 4'h8, 32'hABAB_ABAB, 32'h0,        2'd0, 2);
    vecs[2]  = mk(OP_LB,  32'h0000_0002, 32'h0,        32'h0080_0000, 0, 1, 0, 4'hF, 32'h0,        32'hFFFF_FF80, 2'd0, 2);
    vecs[3]  = mk(OP_LBU, 32'h0000_0002, 32'h0,        32'h0080_0000, 0, 1, 0, 4'hF, 32'h0,        32'h0000_0080, 2'd0, 2);
    vecs[4]  = mk(OP_LW,  32'h0000_0006, 32'h0,        32'h0,        0, 0, 0, 4'h0, 32'h0,        32'h0,        2'd1, 1);
    vecs[5]  = mk(OP_SH,  32'h0000_0002, 32'h1234_BEEF, 32'h0,       0, 1, 1, 4'hC, 32'hBEEF_BEEF, 32'h0,        2'd0, 2);
    vecs[6]  = mk(OP_SH,  32'h0000_0000, 32'h0000_A55A, 32'h0,       0, 1, 1, 4'h3, 32'hA55A_A55A, 32'h0,        2'd0, 2);
    vecs[7]  = mk(OP_SW,  32'h0000_0100, 32'hDEAD_BEEF, 32'h0,       0, 1, 1, 4'hF, 32'hDEAD_BEEF, 32'h0,        2'd0, 2);
    vecs[8]  = mk(OP_LH,  32'h0000_0002, 32'h0,        32'h8001_7FFF, 1, 2, 0, 4'hF, 32'h0,        32'hFFFF_8001, 2'd0, 3);
    vecs[9]  = mk(OP_LHU, 32'h0000_0000, 32'h0,        32'h8001_7FFF, 0, 1, 0, 4'hF, 32'h0,        32'h0000_7FFF, 2'd0, 2);
    vecs[10] = mk(OP_SH,  32'h0000_0001, 32'h1111_2222, 32'h0,       0, 0, 0, 4'h0, 32'h0,        32'h0,        2'd2, 1);
    vecs[11] = mk(OP_LB,  32'h0000_0001, 32'h0,        32'h0000_7F00, 3, 4, 0, 4'hF, 32'h0,        32'h0000_007F, 2'd0, 5);
    vecs[12] = mk(OP_LHU, 32'h0000_0003, 32'h0,        32'h0,        0, 0, 0, 4'h0, 32'h0,        32'h0,        2'd1, 1);
    vecs[13] = mk(OP_SB,  32'h0000_0000, 32'h1234_5655, 32'h0,       0, 1, 1, 4'h1, 32'h5555_5555, 32'h0,        2'd0, 2);
    vecs[14] = mk(OP_LW,  32'h0000_0020, 32'h0,        32'h0,       -1, 4, 0, 4'hF, 32'h0,        32'h0,        2'd3, 5);
    vecs[15] = mk(OP_SW,  32'h0000_001C, 32'hCAFE_F00D, 32'h0,       2, 3, 1, 4'hF, 32'hCAFE_F00D, 32'h0,        2'd0, 4);
    vecs[16] = mk(OP_LB,  32'h0000_0003, 32'h0,        32'h9A00_0000, 0, 1, 0, 4'hF, 32'h0,        32'hFFFF_FF9A, 2'd0, 2);

    // Reset state
    reset = 1'b1; M_instr = 32'h0; M_AR = 32'h0; M_V2 = 32'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_we", {31'h0, mem_we}, 32'h0);
    chk("rst_be", {28'h0, mem_be}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_ldata", m_ldata, 32'h0);
    chk("rst_exc", {30'h0, m_exc}, 32'h0);
    chk("rst_stall", {31'h0, m_stall}, 32'h0);
    chk("rst_state", {30'h0, dbg_state}, {30'h0, ST_IDLE});
    reset = 1'b0;

    // Non-memory ops with a stray ready pulse: nothing happens
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      M_instr = {6'h00 + 6'(i * 8), 26'h155}; M_AR = 32'h0000_0003;
      mem_ready = (i == 1);
      #1;
      chk($sformatf("nop%0d stall", i), {31'h0, m_stall}, 32'h0);
      chk($sformatf("nop%0d req", i), {31'h0, mem_req}, 32'h0);
      chk($sformatf("nop%0d exc", i), {30'h0, m_exc}, 32'h0);
    end

    // Table: ops run back to back
    for (int i = 0; i < 17; i++) run_op(i, vecs[i]);

    // Reset during the second BUSY cycle of a store
    begin
      int  busy;
      bit  hit;
      busy = 0; hit = 0;
      @(negedge clk);
      M_instr = {OP_SW, 26'h0}; M_AR = 32'h0000_0008; M_V2 = 32'h0000_0001;
      mem_ready = 1'b0;
      for (int c = 0; c < 10 && !hit; c++) begin
        #1;
        if (mem_req) busy++;
        if (busy == 2) begin
          hit = 1;
          reset = 1'b1;
        end
        @(negedge clk);
      end
      reset = 1'b0;
      #1;
      chk("rstbusy_reached", {31'h0, hit}, 32'h1);
      chk("rstbusy_req", {31'h0, mem_req}, 32'h0);
      chk("rstbusy_state", {30'h0, dbg_state}, {30'h0, ST_IDLE});
      chk("rstbusy_exc", {30'h0, m_exc}, 32'h0);
      M_instr = 32'h0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        #1;
        chk($sformatf("rstbusy_quiet%0d", c), {29'h0, mem_req, m_exc}, 32'h0);
      end
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
